// File: rtl/load_store_sequencer.sv
// Sequences one CPU load/store at a time onto a simple memory-controller handshake.
// Each access walks IDLE -> ISSUE -> RELEASE and is aborted if ack does not arrive in time.
module load_store_sequencer #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        hwclk,
    input  logic        nrst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_dbl,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        mem_write_en,
    output logic        mem_read_en,
    output logic        dbl_byte_en,
    output logic [15:0] address,
    output logic [15:0] data_in,
    input  logic        ack,
    input  logic [15:0] data_output,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        signed_q, signed_d;
    logic        mem_write_en_q, mem_write_en_d;
    logic        mem_read_en_q, mem_read_en_d;
    logic        dbl_byte_en_q, dbl_byte_en_d;
    logic [15:0] address_q, address_d;
    logic [15:0] data_in_q, data_in_d;
    logic        resp_valid_q, resp_valid_d;
    logic [15:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [15:0] load_data;

    // The memory-side registers double as the latched request for the whole access.
    always_comb begin
        if (dbl_byte_en_q) begin
            load_data = data_output;
        end else if (signed_q) begin
            load_data = {{8{data_output[7]}}, data_output[7:0]};
        end else begin
            load_data = {8'h00, data_output[7:0]};
        end
    end

    always_ff @(posedge hwclk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            signed_q       <= 1'b0;
            mem_write_en_q <= 1'b0;
            mem_read_en_q  <= 1'b0;
            dbl_byte_en_q  <= 1'b0;
            address_q      <= '0;
            data_in_q      <= '0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            signed_q       <= signed_d;
            mem_write_en_q <= mem_write_en_d;
            mem_read_en_q  <= mem_read_en_d;
            dbl_byte_en_q  <= dbl_byte_en_d;
            address_q      <= address_d;
            data_in_q      <= data_in_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_err_q     <= resp_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        signed_d       = signed_q;
        mem_write_en_d = mem_write_en_q;
        mem_read_en_d  = mem_read_en_q;
        dbl_byte_en_d  = dbl_byte_en_q;
        address_d      = address_q;
        data_in_d      = data_in_q;
        resp_valid_d   = 1'b0;
        resp_rdata_d   = resp_rdata_q;
        resp_err_d     = resp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d        = ISSUE;
                    cnt_d          = '0;
                    signed_d       = req_signed;
                    mem_write_en_d = req_write;
                    mem_read_en_d  = ~req_write;
                    dbl_byte_en_d  = req_dbl;
                    address_d      = req_addr;
                    data_in_d      = req_wdata;
                end
            end
            ISSUE: begin
                // ack is checked first so a late ack on the timeout cycle still completes.
                if (ack) begin
                    state_d        = RELEASE;
                    mem_write_en_d = 1'b0;
                    mem_read_en_d  = 1'b0;
                    dbl_byte_en_d  = 1'b0;
                    resp_valid_d   = 1'b1;
                    resp_err_d     = 1'b0;
                    resp_rdata_d   = mem_write_en_q ? 16'h0000 : load_data;
                end else if (cnt_q == LAST_CNT) begin
                    state_d        = RELEASE;
                    mem_write_en_d = 1'b0;
                    mem_read_en_d  = 1'b0;
                    dbl_byte_en_d  = 1'b0;
                    resp_valid_d   = 1'b1;
                    resp_err_d     = 1'b1;
                    resp_rdata_d   = 16'h0000;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready    = (state_q == IDLE);
    assign mem_write_en = mem_write_en_q;
    assign mem_read_en  = mem_read_en_q;
    assign dbl_byte_en  = dbl_byte_en_q;
    assign address      = address_q;
    assign data_in      = data_in_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer: loads, stores, timeout, ignored requests and resets.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_load_store_sequencer;

    logic        hwclk = 1'b0;
    logic        nrst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_dbl = 1'b0;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        mem_write_en;
    logic        mem_read_en;
    logic        dbl_byte_en;
    logic [15:0] address;
    logic [15:0] data_in;
    logic        ack = 1'b0;
    logic [15:0] data_output = '0;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;

    int testsRun = 0;
    int testsFailed = 0;

    load_store_sequencer #(.TIMEOUT_CYCLES(15)) dut (
        .hwclk(hwclk), .nrst(nrst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_dbl(req_dbl), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .dbl_byte_en(dbl_byte_en), .address(address), .data_in(data_in),
        .ack(ack), .data_output(data_output),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 hwclk = ~hwclk;

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    // Presents one request for a single cycle; returns in the first ISSUE cycle.
    task automatic send(input logic w, input logic d, input logic s,
                        input logic [15:0] a, input logic [15:0] wd);
        req_valid = 1'b1; req_write = w; req_dbl = d; req_signed = s;
        req_addr = a; req_wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 nrst = 1'b0;
        #2;
        testsRun++;
        if ({req_ready, mem_write_en, mem_read_en, dbl_byte_en, resp_valid, resp_err} !== 6'b100000) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl got %b expected 100000",
                     {req_ready, mem_write_en, mem_read_en, dbl_byte_en, resp_valid, resp_err});
        end
        testsRun++;
        if ({address, data_in, resp_rdata} !== 48'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data got %h expected 0", {address, data_in, resp_rdata});
        end
        tick();
        tick();
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_load8(input logic sgn, input logic [15:0] expRdata);
        send(1'b0, 1'b0, sgn, 16'h9997, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if ({mem_read_en, mem_write_en, dbl_byte_en, req_ready, resp_valid, address} !==
                {5'b10000, 16'h9997}) begin
                testsFailed++;
                $display("[TB] FAIL load8_issue cyc%0d got %b_%h expected 10000_9997", i,
                         {mem_read_en, mem_write_en, dbl_byte_en, req_ready, resp_valid}, address);
            end
            if (i == 3) begin
                ack = 1'b1;
                data_output = 16'h0090;
            end
            tick();
        end
        ack = 1'b0;
        data_output = 16'hA5A5;
        testsRun++;
        if ({resp_valid, resp_err, resp_rdata, mem_read_en, req_ready} !== {2'b10, expRdata, 2'b00}) begin
            testsFailed++;
            $display("[TB] FAIL load8_resp sgn=%0b got v%b e%b d%h rd%b rdy%b expected v1 e0 d%h rd0 rdy0",
                     sgn, resp_valid, resp_err, resp_rdata, mem_read_en, req_ready, expRdata);
        end
        tick();
        testsRun++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            testsFailed++;
            $display("[TB] FAIL load8_idle got v%b rdy%b expected v0 rdy1", resp_valid, req_ready);
        end
    endtask

    task automatic test_load16();
        send(1'b0, 1'b1, 1'b1, 16'h9985, 16'h0000);
        testsRun++;
        if ({mem_read_en, dbl_byte_en, address} !== {2'b11, 16'h9985}) begin
            testsFailed++;
            $display("[TB] FAIL load16_issue got %b_%h expected 11_9985", {mem_read_en, dbl_byte_en}, address);
        end
        ack = 1'b1;
        data_output = 16'h3210;
        tick();
        data_output = 16'hFFFF;
        testsRun++;
        if ({resp_valid, resp_err, resp_rdata, mem_read_en, dbl_byte_en} !== {2'b10, 16'h3210, 2'b00}) begin
            testsFailed++;
            $display("[TB] FAIL load16_resp got v%b e%b d%h en%b expected v1 e0 d3210 en00",
                     resp_valid, resp_err, resp_rdata, {mem_read_en, dbl_byte_en});
        end
        tick();
        testsRun++;
        if ({resp_valid, req_ready, mem_read_en} !== 3'b010) begin
            testsFailed++;
            $display("[TB] FAIL load16_stray_ack got %b expected 010", {resp_valid, req_ready, mem_read_en});
        end
        tick();
        ack = 1'b0;
        testsRun++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            testsFailed++;
            $display("[TB] FAIL load16_idle got %b expected 01", {resp_valid, req_ready});
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int guard = 0;
        send(1'b1, 1'b0, 1'b0, 16'h7775, 16'h00AB);
        testsRun++;
        if ({mem_write_en, mem_read_en, dbl_byte_en, address, data_in} !== {3'b100, 16'h7775, 16'h00AB}) begin
            testsFailed++;
            $display("[TB] FAIL store_issue got %b_%h_%h expected 100_7775_00ab",
                     {mem_write_en, mem_read_en, dbl_byte_en}, address, data_in);
        end
        while (resp_valid !== 1'b1 && guard < 40) begin
            if (mem_write_en === 1'b1) n++;
            guard++;
            tick();
        end
        testsRun++;
        if (n !== 15 || guard >= 40) begin
            testsFailed++;
            $display("[TB] FAIL store_timeout_len got %0d write cycles (waited %0d) expected 15", n, guard);
        end
        testsRun++;
        if ({resp_valid, resp_err, resp_rdata, mem_write_en} !== {2'b11, 16'h0000, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL store_timeout_resp got v%b e%b d%h we%b expected v1 e1 d0000 we0",
                     resp_valid, resp_err, resp_rdata, mem_write_en);
        end
        tick();
        testsRun++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            testsFailed++;
            $display("[TB] FAIL store_timeout_idle got %b expected 01", {resp_valid, req_ready});
        end
    endtask

    task automatic test_ack_on_timeout();
        send(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000);
        repeat (14) tick();
        testsRun++;
        if ({mem_read_en, resp_valid} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL last_issue_cycle got %b expected 10", {mem_read_en, resp_valid});
        end
        ack = 1'b1;
        data_output = 16'h0055;
        tick();
        ack = 1'b0;
        testsRun++;
        if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 16'h0055}) begin
            testsFailed++;
            $display("[TB] FAIL ack_wins got v%b e%b d%h expected v1 e0 d0055", resp_valid, resp_err, resp_rdata);
        end
        tick();
    endtask

    task automatic test_ignore_valid();
        int resps = 0;
        send(1'b0, 1'b0, 1'b0, 16'h4000, 16'h0000);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h5000;
        testsRun++;
        if (req_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ignore_ready got %b expected 0", req_ready);
        end
        tick();
        req_valid = 1'b0;
        testsRun++;
        if ({req_ready, mem_read_en, mem_write_en, address} !== {3'b010, 16'h4000}) begin
            testsFailed++;
            $display("[TB] FAIL ignore_hold got %b_%h expected 010_4000",
                     {req_ready, mem_read_en, mem_write_en}, address);
        end
        ack = 1'b1;
        data_output = 16'h00C3;
        tick();
        ack = 1'b0;
        testsRun++;
        if ({resp_valid, resp_rdata, req_ready} !== {1'b1, 16'h00C3, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL ignore_resp got v%b d%h rdy%b expected v1 d00c3 rdy0",
                     resp_valid, resp_rdata, req_ready);
        end
        for (int i = 0; i < 8; i++) begin
            if (resp_valid === 1'b1) resps++;
            tick();
        end
        testsRun++;
        if (resps !== 1 || req_ready !== 1'b1 || mem_write_en !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ignore_count got %0d responses rdy%b we%b expected 1 rdy1 we0",
                     resps, req_ready, mem_write_en);
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        req_valid = 1'b1; req_write = 1'b0; req_dbl = 1'b1; req_signed = 1'b0;
        req_addr = 16'h2222;
        ack = 1'b1;
        data_output = 16'h1234;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 8) req_valid = 1'b0;
            if (req_ready === 1'b1) accepts++;
            testsRun++;
            if (resp_valid !== ((i % 3) == 1) ||
                (resp_valid === 1'b1 && resp_rdata !== 16'h1234)) begin
                testsFailed++;
                $display("[TB] FAIL b2b_cycle%0d got v%b d%h expected v%0b d1234",
                         i, resp_valid, resp_rdata, ((i % 3) == 1));
            end
        end
        ack = 1'b0;
        testsRun++;
        if (accepts !== 3) begin
            testsFailed++;
            $display("[TB] FAIL b2b_ready got %0d idle cycles expected 3", accepts);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int resps = 0;
        send(1'b1, 1'b1, 1'b0, 16'h9992, 16'h7654);
        testsRun++;
        if ({mem_write_en, dbl_byte_en, address, data_in} !== {2'b11, 16'h9992, 16'h7654}) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_issue got %b_%h_%h expected 11_9992_7654",
                     {mem_write_en, dbl_byte_en}, address, data_in);
        end
        tick();
        tick();
        nrst = 1'b0;
        #1;
        testsRun++;
        if ({mem_write_en, mem_read_en, dbl_byte_en, address, data_in, resp_valid, resp_err, resp_rdata,
             req_ready} !== {37'h0, 16'h0000, 1'b1}) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_async got en%b a%h d%h v%b e%b r%h rdy%b expected all 0 rdy1",
                     {mem_write_en, mem_read_en, dbl_byte_en}, address, data_in,
                     resp_valid, resp_err, resp_rdata, req_ready);
        end
        #2 nrst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp_valid === 1'b1) resps++;
        end
        testsRun++;
        if (resps !== 0 || req_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_noresp got %0d responses rdy%b expected 0 rdy1", resps, req_ready);
        end
        send(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        ack = 1'b1;
        data_output = 16'hBEEF;
        tick();
        ack = 1'b0;
        testsRun++;
        if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 16'hBEEF}) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_next got v%b e%b d%h expected v1 e0 dbeef", resp_valid, resp_err, resp_rdata);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_load8(1'b0, 16'h0090);
        test_load8(1'b1, 16'hFF90);
        test_load16();
        test_timeout();
        test_ack_on_timeout();
        test_ignore_valid();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
